sync_fifo_ctrl: RTL and testbench

//  Single-clock controller that sequences the fifo_sram dual-port array as a synchronous FIFO.

---
 rtl/sync_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller that sequences a dual-port SRAM (wrclk = rdclk = clk).
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_ctrl #(
    parameter int FIFO_PTR   = 10,
    parameter int AFULL_LVL  = (2**FIFO_PTR) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    output logic                wren,
    output logic [FIFO_PTR-1:0] wrptr,
    output logic                rden,
    output logic [FIFO_PTR-1:0] rdptr,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [FIFO_PTR:0]   count,
    input  logic                err_clr,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [FIFO_PTR:0]   DEPTH_C  = {1'b1, {FIFO_PTR{1'b0}}};
    localparam logic [FIFO_PTR:0]   AFULL_C  = AFULL_LVL[FIFO_PTR:0];
    localparam logic [FIFO_PTR:0]   AEMPTY_C = AEMPTY_LVL[FIFO_PTR:0];
    localparam logic [FIFO_PTR:0]   CNT_ONE  = {{FIFO_PTR{1'b0}}, 1'b1};
    localparam logic [FIFO_PTR-1:0] PTR_ONE  = CNT_ONE[FIFO_PTR-1:0];

    logic [FIFO_PTR-1:0] wrptr_q, wrptr_d;
    logic [FIFO_PTR-1:0] rdptr_q, rdptr_d;
    logic [FIFO_PTR:0]   count_q, count_d;
    logic                rd_valid_q;
    logic                full_q, empty_q, afull_q, aempty_q;

    always_comb begin
        // Accept decisions use only registered flags: no write-through when full, no bypass when empty.
        wren    = push & ~full_q;
        rden    = pop & ~empty_q;
        wrptr_d = wren ? wrptr_q + PTR_ONE : wrptr_q;
        rdptr_d = rden ? rdptr_q + PTR_ONE : rdptr_q;
        count_d = count_q;
        if (wren && !rden) begin
            count_d = count_q + CNT_ONE;
        end else if (!wren && rden) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr_q    <= '0;
            rdptr_q    <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
        end else begin
            wrptr_q    <= wrptr_d;
            rdptr_q    <= rdptr_d;
            count_q    <= count_d;
            rd_valid_q <= rden;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            afull_q    <= (count_d >= AFULL_C);
            aempty_q   <= (count_d <= AEMPTY_C);
        end
    end

    assign wrptr        = wrptr_q;
    assign rdptr        = rdptr_q;
    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr wins, so the flag stays set.
    always_comb begin
        overflow_d  = (overflow_q & ~err_clr) | (push & full_q);
        underflow_d = (underflow_q & ~err_clr) | (pop & empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (FIFO_PTR=2) with a behavioural SRAM and a read-data scoreboard.
module tb_sync_fifo_ctrl;

`ifdef SYNC_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic       wren, rden, rd_valid, full, empty, almost_full, almost_empty;
    logic       overflow, underflow;
    logic [1:0] wrptr, rdptr;
    logic [2:0] count;
    logic [7:0] wrdata = 8'h00;
    logic [7:0] rddata;
    logic [7:0] mem [4];

    int n_total = 0;
    int n_pass  = 0;
    int n_rd    = 0;
    logic [7:0] expq [$];

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.FIFO_PTR(2), .AFULL_LVL(2), .AEMPTY_LVL(1)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .wren(wren), .wrptr(wrptr), .rden(rden), .rdptr(rdptr),
        .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    // Behavioural SRAM: registered read, both ports on clk.
    always @(posedge clk) begin
        if (wren) mem[wrptr] <= wrdata;
        if (rden) rddata <= mem[rdptr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every rd_valid must match the oldest accepted push.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            n_rd++;
            if (expq.size() == 0) begin
                n_total++;
                $display("FAIL rd_data: got %0h expected none (queue empty)", rddata);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                chk("rd_data", {24'd0, rddata}, {24'd0, e});
                $display("read %0d: data=%0h expected=%0h", n_rd, rddata, e);
            end
        end
    end

    task automatic step(input logic p, input logic q, input logic c, input logic [7:0] d,
                        input logic ew, input logic er);
        push = p; pop = q; err_clr = c; wrdata = d;
        #1;
        chk("wren", {31'd0, wren}, {31'd0, ew});
        chk("rden", {31'd0, rden}, {31'd0, er});
        if (ew) expq.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        $display("step push=%0b pop=%0b clr=%0b data=%0h -> count=%0d wr=%0d rd=%0d",
                 p, q, c, d, count, wrptr, rdptr);
    endtask

    // Registered-state check: count, full, empty, almost_full, almost_empty, wrptr, rdptr.
    task automatic st(input string name, input logic [2:0] c, input logic f, input logic e,
                      input logic af, input logic ae, input logic [1:0] w, input logic [1:0] r);
        chk({name, ".count"}, {29'd0, count}, {29'd0, c});
        chk({name, ".flags"}, {28'd0, full, empty, almost_full, almost_empty},
            {28'd0, f, e, af, ae});
        chk({name, ".ptrs"}, {28'd0, wrptr, rdptr}, {28'd0, w, r});
    endtask

    task automatic errs(input string name, input logic ov, input logic un);
        chk({name, ".err"}, {30'd0, overflow, underflow}, {30'd0, ov, un});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset then idle
        #23; @(posedge clk); #1; rst = 1'b0;
        st("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
        chk("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
        errs("reset", 1'b0, 1'b0);
        step(0, 0, 0, 8'h00, 0, 0);
        st("idle", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);

        // 2. fill, then push into full
        step(1, 0, 0, 8'hA0, 1, 0); st("push1", 3'd1, 0, 0, 0, 1, 2'd1, 2'd0);
        step(1, 0, 0, 8'hA1, 1, 0); st("push2", 3'd2, 0, 0, 1, 0, 2'd2, 2'd0);
        step(1, 0, 0, 8'hA2, 1, 0); st("push3", 3'd3, 0, 0, 1, 0, 2'd3, 2'd0);
        step(1, 0, 0, 8'hA3, 1, 0); st("push4", 3'd4, 1, 0, 1, 0, 2'd0, 2'd0);
        step(1, 0, 0, 8'hA4, 0, 0); st("push_full", 3'd4, 1, 0, 1, 0, 2'd0, 2'd0);
        errs("overflow", ERR, 1'b0);

        // 3. drain
        step(0, 1, 0, 8'h00, 0, 1); st("pop1", 3'd3, 0, 0, 1, 0, 2'd0, 2'd1);
        chk("pop1.rd_valid", {31'd0, rd_valid}, 32'd1);
        step(0, 1, 0, 8'h00, 0, 1); st("pop2", 3'd2, 0, 0, 1, 0, 2'd0, 2'd2);
        step(0, 1, 0, 8'h00, 0, 1); st("pop3", 3'd1, 0, 0, 0, 1, 2'd0, 2'd3);
        step(0, 1, 0, 8'h00, 0, 1); st("pop4", 3'd0, 0, 1, 0, 1, 2'd0, 2'd0);
        chk("pop4.rd_valid", {31'd0, rd_valid}, 32'd1);
        step(0, 0, 0, 8'h00, 0, 0);
        chk("idle.rd_valid", {31'd0, rd_valid}, 32'd0);

        // 4. pop while empty with simultaneous push
        step(1, 1, 0, 8'hB0, 1, 0); st("pop_empty", 3'd1, 0, 0, 0, 1, 2'd1, 2'd0);
        errs("underflow", ERR, ERR);
        step(0, 1, 0, 8'h00, 0, 1); st("pop_b0", 3'd0, 0, 1, 0, 1, 2'd1, 2'd1);
        step(0, 0, 1, 8'h00, 0, 0); errs("clear", 1'b0, 1'b0);

        // 5. steady push+pop at count=2
        step(1, 0, 0, 8'hC0, 1, 0);
        step(1, 0, 0, 8'hC1, 1, 0); st("cnt2", 3'd2, 0, 0, 1, 0, 2'd3, 2'd1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 8'hD0 + 8'(i), 1, 1);
            chk("stream.count", {29'd0, count}, 32'd2);
            chk("stream.afull", {31'd0, almost_full}, 32'd1);
        end
        st("stream_end", 3'd2, 0, 0, 1, 0, 2'd1, 2'd3);

        // 6. asynchronous reset mid-stream with rd_valid high
        step(1, 0, 0, 8'hE0, 1, 0);
        step(1, 1, 0, 8'hE1, 1, 1); st("pre_rst", 3'd3, 0, 0, 1, 0, 2'd3, 2'd0);
        chk("pre_rst.rd_valid", {31'd0, rd_valid}, 32'd1);
        rst = 1'b1;
        #1;
        st("async_rst", 3'd0, 0, 1, 0, 1, 2'd0, 2'd0);
        chk("async_rst.rd_valid", {31'd0, rd_valid}, 32'd0);
        errs("async_rst", 1'b0, 1'b0);
        expq.delete();
        @(posedge clk); #1; rst = 1'b0;
        step(0, 1, 1, 8'h00, 0, 0); errs("clr_vs_err", 1'b0, ERR);
        step(0, 0, 0, 8'h00, 0, 0); errs("sticky", 1'b0, ERR);
        step(0, 0, 1, 8'h00, 0, 0); errs("clr_only", 1'b0, 1'b0);
        step(1, 0, 0, 8'hF0, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1); st("post_rst", 3'd0, 0, 1, 0, 1, 2'd1, 2'd1);

        // every accepted word must have come out
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        chk("drain.pending", expq.size(), 32'd0);
        chk("drain.reads", n_rd, 32'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
